// File: rtl/control_unit_if.sv
// Memory bus between the accumulator CPU sequencer (master) and program/data
// memory (slave). Read data is combinational: valid in the same cycle as the
// address and read strobe.
interface control_unit_if;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/control_unit.sv
// Instruction sequencer for the basic accumulator CPU.
// Driven by the one-hot T0..T3 slots of an external timing counter; fetches,
// decodes and executes 8-bit instructions (I | opcode[2:0] | addr[3:0]).
// sc_clr sends the counter back to T0 to end short instructions, to hold it
// while halted, and to resynchronise it after an illegal slot pattern.
// Optional feature macro: CTRL_INDIRECT_EN enables indirect addressing
// (ir[7]=1 fetches the effective address from memory during T1).
//
// Slot | action
// T0   | fetch ir <= mem[pc], pc <= pc+1
// T1   | ea <= address field (or indirect read); NOP/HLT end here
// T2   | operand read (LDA/ADD/AND), store (STA), jumps; STA/JMP/JZ end here
// T3   | accumulator load for LDA/ADD/AND; counter wraps to T0
module control_unit (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [3:0]            t,
    input  logic                  ac_zero,
    control_unit_if.master        mem,
    output logic                  ac_ld,
    output logic [1:0]            alu_op,
    output logic [7:0]            dr,
    output logic [3:0]            pc,
    output logic [7:0]            ir,
    output logic                  sc_clr,
    output logic                  halted
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDA = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_STA = 3'd4,
        OP_JMP = 3'd5,
        OP_JZ  = 3'd6,
        OP_HLT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        SLOT_T0,
        SLOT_T1,
        SLOT_T2,
        SLOT_T3,
        SLOT_BAD
    } slot_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;

    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] ea_q, ea_d;
    logic [7:0] dr_q, dr_d;
    logic       halted_q, halted_d;

    logic [3:0] mem_addr_c;
    logic       mem_rd_c;
    logic       mem_wr_c;
    logic       ac_ld_c;
    logic [1:0] alu_op_c;
    logic       sc_clr_c;

    slot_e   slot;
    opcode_e opcode;

    assign opcode = opcode_e'(ir_q[6:4]);

    // Classify the timing input; anything not exactly one-hot is illegal.
    always_comb begin
        slot = SLOT_BAD;
        case (t)
            4'b0001: slot = SLOT_T0;
            4'b0010: slot = SLOT_T1;
            4'b0100: slot = SLOT_T2;
            4'b1000: slot = SLOT_T3;
            default: slot = SLOT_BAD;
        endcase
    end

    // Strobes and next-state for the architectural registers.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ea_d       = ea_q;
        dr_d       = dr_q;
        halted_d   = halted_q;
        mem_addr_c = 4'd0;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        ac_ld_c    = 1'b0;
        alu_op_c   = ALU_PASS;
        sc_clr_c   = 1'b0;

        if (clr) begin
            // Reset is applied in the flop block; everything quiet here.
        end else if (halted_q || slot == SLOT_BAD) begin
            sc_clr_c = 1'b1;
        end else begin
            case (slot)
                SLOT_T0: begin
                    mem_addr_c = pc_q;
                    mem_rd_c   = 1'b1;
                    ir_d       = mem.mem_rdata;
                    pc_d       = pc_q + 4'd1;
                end
                SLOT_T1: begin
                    ea_d = ir_q[3:0];
                    if (opcode == OP_NOP) begin
                        sc_clr_c = 1'b1;
                    end else if (opcode == OP_HLT) begin
                        halted_d = 1'b1;
                        sc_clr_c = 1'b1;
                    end else begin
`ifdef CTRL_INDIRECT_EN
                        if (ir_q[7]) begin
                            mem_addr_c = ir_q[3:0];
                            mem_rd_c   = 1'b1;
                            ea_d       = mem.mem_rdata[3:0];
                        end
`endif
                    end
                end
                SLOT_T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_AND: begin
                            mem_addr_c = ea_q;
                            mem_rd_c   = 1'b1;
                            dr_d       = mem.mem_rdata;
                        end
                        OP_STA: begin
                            mem_addr_c = ea_q;
                            mem_wr_c   = 1'b1;
                            sc_clr_c   = 1'b1;
                        end
                        OP_JMP: begin
                            pc_d     = ea_q;
                            sc_clr_c = 1'b1;
                        end
                        OP_JZ: begin
                            if (ac_zero) begin
                                pc_d = ea_q;
                            end
                            sc_clr_c = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                SLOT_T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ac_ld_c  = 1'b1;
                            alu_op_c = ALU_PASS;
                        end
                        OP_ADD: begin
                            ac_ld_c  = 1'b1;
                            alu_op_c = ALU_ADD;
                        end
                        OP_AND: begin
                            ac_ld_c  = 1'b1;
                            alu_op_c = ALU_AND;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural registers with synchronous reset on clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q     <= 4'd0;
            ir_q     <= 8'd0;
            ea_q     <= 4'd0;
            dr_q     <= 8'd0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ea_q     <= ea_d;
            dr_q     <= dr_d;
            halted_q <= halted_d;
        end
    end

    assign mem.mem_addr = mem_addr_c;
    assign mem.mem_rd   = mem_rd_c;
    assign mem.mem_wr   = mem_wr_c;
    assign ac_ld        = ac_ld_c;
    assign alu_op       = alu_op_c;
    assign sc_clr       = sc_clr_c;
    assign dr           = dr_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: models the T0..T3 timing counter
// (cleared by clr | sc_clr) and a 16x8 combinational memory.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ac_zero = 1'b0;
    logic       inject = 1'b0;
    logic [3:0] t_inj = 4'b0000;
    logic [3:0] t_cnt = 4'b0001;
    logic [3:0] t;
    logic       ac_ld;
    logic [1:0] alu_op;
    logic [7:0] dr;
    logic [3:0] pc;
    logic [7:0] ir;
    logic       sc_clr;
    logic       halted;
    logic [7:0] mem [16];

    integer n_checks = 0;
    integer n_fail   = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk     (clk),
        .clr     (clr),
        .t       (t),
        .ac_zero (ac_zero),
        .mem     (bus.master),
        .ac_ld   (ac_ld),
        .alu_op  (alu_op),
        .dr      (dr),
        .pc      (pc),
        .ir      (ir),
        .sc_clr  (sc_clr),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (clr || sc_clr) t_cnt <= 4'b0001;
        else               t_cnt <= {t_cnt[2:0], t_cnt[3]};
    end

    assign t = inject ? t_inj : t_cnt;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    // Holds clr for two cycles, returns at a negedge in T0 with clr low.
    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_mem();
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({pc, ir, dr, halted} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_regs: pc=%h ir=%h dr=%h halted=%b, want all 0", pc, ir, dr, halted);
        end
        n_checks++;
        if ({bus.mem_rd, bus.mem_wr, ac_ld, sc_clr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: rd=%b wr=%b ac_ld=%b sc_clr=%b, want 0", bus.mem_rd, bus.mem_wr, ac_ld, sc_clr);
        end
    endtask

    task automatic test_lda();
        clear_mem();
        mem[0] = 8'h13;
        mem[3] = 8'h5A;
        do_reset();
        n_checks++;
        if ({t, bus.mem_rd, bus.mem_addr} !== {4'b0001, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL lda_t0: t=%b rd=%b addr=%h, want 0001 1 0", t, bus.mem_rd, bus.mem_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({ir, pc, bus.mem_rd, sc_clr} !== {8'h13, 4'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL lda_t1: ir=%h pc=%h rd=%b sc_clr=%b, want 13 1 0 0", ir, pc, bus.mem_rd, sc_clr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.mem_rd, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL lda_t2: rd=%b wr=%b addr=%h, want 1 0 3", bus.mem_rd, bus.mem_wr, bus.mem_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({ac_ld, alu_op, dr, pc} !== {1'b1, 2'b00, 8'h5A, 4'd1}) begin
            n_fail++;
            $display("FAIL lda_t3: ac_ld=%b alu_op=%b dr=%h pc=%h, want 1 00 5a 1", ac_ld, alu_op, dr, pc);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({t, bus.mem_addr} !== {4'b0001, 4'd1}) begin
            n_fail++;
            $display("FAIL lda_next: t=%b addr=%h, want 0001 1", t, bus.mem_addr);
        end
    endtask

    task automatic test_sta();
        clear_mem();
        mem[0] = 8'h47;
        do_reset();
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({bus.mem_wr, bus.mem_rd, bus.mem_addr, sc_clr} !== {1'b1, 1'b0, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL sta_t2: wr=%b rd=%b addr=%h sc_clr=%b, want 1 0 7 1", bus.mem_wr, bus.mem_rd, bus.mem_addr, sc_clr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({t, bus.mem_rd, bus.mem_addr} !== {4'b0001, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL sta_next: t=%b rd=%b addr=%h, want 0001 1 1", t, bus.mem_rd, bus.mem_addr);
        end
    endtask

    task automatic test_jz(input logic zero, input logic [3:0] exp_pc);
        clear_mem();
        mem[0] = 8'h69;
        ac_zero = zero;
        do_reset();
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({sc_clr, bus.mem_rd, bus.mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL jz_t2(z=%b): sc_clr=%b rd=%b wr=%b, want 1 0 0", zero, sc_clr, bus.mem_rd, bus.mem_wr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({pc, t} !== {exp_pc, 4'b0001}) begin
            n_fail++;
            $display("FAIL jz_pc(z=%b): pc=%h t=%b, want %h 0001", zero, pc, t, exp_pc);
        end
        ac_zero = 1'b0;
    endtask

    task automatic test_nop_wrap();
        clear_mem();
        mem[0]  = 8'h5F;
        mem[15] = 8'h00;
        do_reset();
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (sc_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_t2: sc_clr=%b, want 1", sc_clr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({t, bus.mem_rd, bus.mem_addr} !== {4'b0001, 1'b1, 4'hF}) begin
            n_fail++;
            $display("FAIL jmp_target_fetch: t=%b rd=%b addr=%h, want 0001 1 f", t, bus.mem_rd, bus.mem_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({pc, sc_clr, ir} !== {4'd0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL nop_t1: pc=%h sc_clr=%b ir=%h, want 0 1 00", pc, sc_clr, ir);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({t, bus.mem_addr, bus.mem_rd} !== {4'b0001, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL nop_next: t=%b addr=%h rd=%b, want 0001 0 1", t, bus.mem_addr, bus.mem_rd);
        end
    endtask

    task automatic test_hlt();
        int rd_seen;
        int sc_low;
        clear_mem();
        mem[0] = 8'h70;
        do_reset();
        @(negedge clk); #1;
        n_checks++;
        if ({sc_clr, halted} !== 2'b10) begin
            n_fail++;
            $display("FAIL hlt_t1: sc_clr=%b halted=%b, want 1 0", sc_clr, halted);
        end
        rd_seen = 0;
        sc_low  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (bus.mem_rd || bus.mem_wr || ac_ld) rd_seen++;
            if (!sc_clr || !halted) sc_low++;
        end
        n_checks++;
        if (rd_seen !== 0 || sc_low !== 0) begin
            n_fail++;
            $display("FAIL hlt_hold: strobe_cycles=%0d sc_clr_or_halt_low=%0d, want 0 0", rd_seen, sc_low);
        end
        n_checks++;
        if ({pc, ir} !== {4'd1, 8'h70}) begin
            n_fail++;
            $display("FAIL hlt_frozen: pc=%h ir=%h, want 1 70", pc, ir);
        end
        do_reset();
        n_checks++;
        if ({pc, halted, bus.mem_rd} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL hlt_clr: pc=%h halted=%b rd=%b, want 0 0 1", pc, halted, bus.mem_rd);
        end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[0] = 8'h23;
        mem[1] = 8'h34;
        mem[3] = 8'h11;
        mem[4] = 8'h22;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({ac_ld, alu_op, dr} !== {1'b1, 2'b01, 8'h11}) begin
            n_fail++;
            $display("FAIL add_t3: ac_ld=%b alu_op=%b dr=%h, want 1 01 11", ac_ld, alu_op, dr);
        end
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if ({ac_ld, alu_op, dr, pc} !== {1'b1, 2'b10, 8'h22, 4'd2}) begin
            n_fail++;
            $display("FAIL and_t3: ac_ld=%b alu_op=%b dr=%h pc=%h, want 1 10 22 2", ac_ld, alu_op, dr, pc);
        end
    endtask

    task automatic test_indirect();
        logic       exp_t1_rd;
        logic [3:0] exp_t2_addr;
        logic [7:0] exp_dr;
`ifdef CTRL_INDIRECT_EN
        exp_t1_rd   = 1'b1;
        exp_t2_addr = 4'd11;
        exp_dr      = 8'hC3;
`else
        exp_t1_rd   = 1'b0;
        exp_t2_addr = 4'd2;
        exp_dr      = 8'h0B;
`endif
        clear_mem();
        mem[0]  = 8'h92;
        mem[2]  = 8'h0B;
        mem[11] = 8'hC3;
        do_reset();
        @(negedge clk); #1;
        n_checks++;
        if (bus.mem_rd !== exp_t1_rd || (exp_t1_rd && bus.mem_addr !== 4'd2)) begin
            n_fail++;
            $display("FAIL ind_t1: rd=%b addr=%h, want rd=%b addr=2", bus.mem_rd, bus.mem_addr, exp_t1_rd);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.mem_rd, bus.mem_addr} !== {1'b1, exp_t2_addr}) begin
            n_fail++;
            $display("FAIL ind_t2: rd=%b addr=%h, want 1 %h", bus.mem_rd, bus.mem_addr, exp_t2_addr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({ac_ld, dr} !== {1'b1, exp_dr}) begin
            n_fail++;
            $display("FAIL ind_dr: ac_ld=%b dr=%h, want 1 %h", ac_ld, dr, exp_dr);
        end
    endtask

    task automatic test_bad_t();
        clear_mem();
        mem[0] = 8'h13;
        mem[3] = 8'h5A;
        do_reset();
        repeat (4) @(negedge clk);
        inject = 1'b1;
        t_inj  = 4'b0110;
        #1;
        n_checks++;
        if ({bus.mem_rd, bus.mem_wr, ac_ld, bus.mem_addr, sc_clr} !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_t_strobes: rd=%b wr=%b ac_ld=%b addr=%h sc_clr=%b, want 0 0 0 0 1",
                     bus.mem_rd, bus.mem_wr, ac_ld, bus.mem_addr, sc_clr);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({pc, ir, dr} !== {4'd1, 8'h13, 8'h5A}) begin
            n_fail++;
            $display("FAIL bad_t_regs: pc=%h ir=%h dr=%h, want 1 13 5a", pc, ir, dr);
        end
        inject = 1'b0;
        #1;
        n_checks++;
        if ({t, bus.mem_addr} !== {4'b0001, 4'd1}) begin
            n_fail++;
            $display("FAIL bad_t_resync: t=%b addr=%h, want 0001 1", t, bus.mem_addr);
        end
    endtask

    task automatic test_abort();
        clear_mem();
        mem[0] = 8'h13;
        mem[3] = 8'h5A;
        do_reset();
        repeat (2) @(negedge clk);
        clr = 1'b1;
        #1;
        n_checks++;
        if ({bus.mem_rd, bus.mem_wr, sc_clr} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_strobes: rd=%b wr=%b sc_clr=%b, want 0 0 0", bus.mem_rd, bus.mem_wr, sc_clr);
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        n_checks++;
        if ({t, pc, dr, bus.mem_addr} !== {4'b0001, 4'd0, 8'h00, 4'd0}) begin
            n_fail++;
            $display("FAIL abort_restart: t=%b pc=%h dr=%h addr=%h, want 0001 0 00 0", t, pc, dr, bus.mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sta();
        test_jz(1'b1, 4'd9);
        test_jz(1'b0, 4'd1);
        test_nop_wrap();
        test_hlt();
        test_back_to_back();
        test_indirect();
        test_bad_t();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the basic accumulator CPU. It consumes the one-hot timing slots t[3:0] from the T0–T3 timing counter, fetches and decodes 8-bit instructions, holds PC/IR/EA/DR, and drives memory and accumulator strobes. It returns `sc_clr` to the timing counter to end short instructions early or to freeze sequencing on halt. System wiring: the counter's clr input = `clr | sc_clr`.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- t  input  4  one-hot timing slot from the timing counter (t[0]=T0 … t[3]=T3)
- mem_rdata  input  8  memory read data, valid in the same cycle as mem_addr/mem_rd
- ac_zero  input  1  accumulator == 0 (from datapath)
- mem_addr  output  4  memory address
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe (datapath drives write data from AC)
- ac_ld  output  1  load accumulator with ALU result this cycle
- alu_op  output  2  00 pass DR, 01 AC+DR, 10 AC&DR, 11 unused
- dr  output  8  operand data register
- pc  output  4  program counter
- ir  output  8  instruction register
- sc_clr  output  1  clear request to the timing counter
- halted  output  1  HLT executed

## Operation
- Instruction: ir[7]=I (indirect), ir[6:4]=opcode, ir[3:0]=address.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 AND, 4 STA, 5 JMP, 6 JZ, 7 HLT.
- T0 (all): mem_addr=pc, mem_rd=1; ir<=mem_rdata; pc<=pc+1 (4-bit, 15 wraps to 0).
- T1: ea<=ir[3:0] (direct). NOP: sc_clr=1. HLT: halted<=1, sc_clr=1.
- T2:
  - LDA/ADD/AND: mem_addr=ea, mem_rd=1, dr<=mem_rdata.
  - STA: mem_addr=ea, mem_wr=1, sc_clr=1.
  - JMP: pc<=ea, sc_clr=1.
  - JZ: pc<=ea only if ac_zero=1; sc_clr=1.
- T3: LDA ac_ld=1, alu_op=00; ADD ac_ld=1, alu_op=01; AND ac_ld=1, alu_op=10. The counter then wraps naturally to T0.
- Outputs not listed for a slot are 0. mem_addr is 0 when neither strobe is active.
- Halted: all strobes are 0 and sc_clr=1 continuously. pc, ir, ea and dr are frozen until clr.
- Bad t (not exactly one bit set): all strobes 0, no register updates, sc_clr=1 so the counter resynchronises to T0.

## Timing
- Reset: pc=0, ir=0, ea=0, dr=0, halted=0. While clr=1, all strobes and sc_clr are 0 and no register updates occur.
- Registers update on the rising edge ending the slot. Strobes are combinational from t, ir and halted.
- sc_clr asserted in slot Tn gives t[0]=1 on the next cycle.
- Instruction lengths: NOP/HLT 2 cycles; STA/JMP/JZ 3 cycles; LDA/ADD/AND 4 cycles.
- The ir captured at the end of T0 is used for decode from T1.
- clr during any slot aborts the instruction. No strobes are issued that cycle, and fetch restarts at pc=0 once the counter reaches T0.
- JMP/JZ override the T0 increment. A jump to the current address is legal and loops.

## Configuration
- CTRL_INDIRECT_EN defined:
  - If ir[7]=1, T1 drives mem_addr=ir[3:0], mem_rd=1, and ea<=mem_rdata[3:0].
  - NOP and HLT ignore I.
  - No extra cycles.
- Undefined: ir[7] is ignored, ea<=ir[3:0] always, and there is no T1 read.

## Test plan
- Reset, then memory[0]=0x13 (LDA 3), memory[3]=0x5A → T0 read at addr 0, T2 read at addr 3, T3 ac_ld=1 with alu_op=00 and dr=0x5A, pc=1, next cycle t[0].
- memory[0]=0x47 (STA 7) → T2 mem_wr=1, mem_addr=7, sc_clr=1; next cycle T0 fetches addr 1.
- memory[0]=0x69 (JZ 9): with ac_zero=1 → pc=9 after T2; repeated with ac_zero=0 → pc=1. sc_clr=1 at T2 in both cases.
- memory[15]=0x00 (NOP) executed from pc=15 → pc wraps to 0, sc_clr at T1, 2-cycle instruction.
- memory[0]=0x70 (HLT) → halted=1 after T1, sc_clr held at 1, no mem_rd for 20 cycles; clr then pc=0, halted=0.
- With CTRL_INDIRECT_EN: memory[0]=0x92 (LDA @2), memory[2]=0x0B, memory[11]=0xC3 → T1 read at addr 2, T2 read at addr 11, dr=0xC3. Without the macro, the same program reads addr 2 at T2 and gives dr=0x0B.
- Inject t=4'b0110 → no strobes, sc_clr=1, registers unchanged.
